key_debounce_array: RTL and testbench

Parametrised multi-channel debouncer for the board push-buttons and DIP switches. Each of N channels is synchronised into `clk` and stable-time filtered: a new level is accepted only after it has held unchanged for a full window. Each channel emits a clean level plus one-cycle press/release pulses to the CPU's I/O register block. An optional long-press detector can be compiled in.

---
 rtl/key_debounce_array.sv | 121 ++++++++++++
 tb/tb_key_debounce_array.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// key_debounce_array: N-channel push-button / DIP-switch debouncer.
// Each channel: optional inversion, 2-flop synchroniser, stable-time filter
// FSM with terminal-count counter, registered level and press/release pulses.
// Optional long-press detector compiled in with `define KEY_LONGPRESS_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// STABLE | synchronised input matches key_out; counter held at 0
// COUNT  | input differs from key_out; counting toward the full window
module key_debounce_array #(
  parameter int              N               = 5,
  parameter int              DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [N-1:0]    INVERT          = {N{1'b0}},
  parameter int              LONG_CYCLES     = 50_000_000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_rise,
  output logic [N-1:0] key_fall,
  output logic [N-1:0] key_long
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          raw;
    logic          s1;
    logic          s2;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          rise;
    logic          fall;
    logic          lng;

    assign raw = key_in[i] ^ INVERT[i];

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= raw;
        s2 <= s1;
      end
    end

    // Stable-time filter: accept a new level only after a full unbroken window.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state <= ST_STABLE;
        cnt   <= '0;
        lvl   <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          ST_STABLE: begin
            cnt <= '0;
            if (s2 != lvl) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (s2 == lvl) begin
              // bounce back: restart from scratch on the next change
              state <= ST_STABLE;
              cnt   <= '0;
            end else if (cnt == TC) begin
              lvl   <= s2;
              rise  <= s2;
              fall  <= ~s2;
              state <= ST_STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

`ifdef KEY_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] L_TOP = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] L_HIT = LW'(LONG_CYCLES - 1);
    logic [LW-1:0] hold;

    // Hold timer: counts while pressed, saturates so only one pulse per press.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        hold <= '0;
        lng  <= 1'b0;
      end else begin
        lng <= lvl && (hold == L_HIT);
        if (!lvl)              hold <= '0;
        else if (hold != L_TOP) hold <= hold + 1'b1;
      end
    end
`else
    assign lng = 1'b0;
`endif

    assign key_out[i]  = lvl;
    assign key_rise[i] = rise;
    assign key_fall[i] = fall;
    assign key_long[i] = lng;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array (N=4, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=10, INVERT=4'b0100). Expected values hand-derived from the
// edge-by-edge latency: key_out updates 7 edges after a raw change.
module tb_key_debounce_array;

  logic       clk;
  logic       nrst;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_rise;
  logic [3:0] key_fall;
  logic [3:0] key_long;

  int n_chk;
  int n_pass;

  key_debounce_array #(
    .N(4),
    .DEBOUNCE_CYCLES(4),
    .INVERT(4'b0100),
    .LONG_CYCLES(10)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .key_in(key_in),
    .key_out(key_out),
    .key_rise(key_rise),
    .key_fall(key_fall),
    .key_long(key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    nrst   = 1'b0;
    key_in = 4'b0100;
    #12;
    chk("rst_out",  32'(key_out),  32'h0);
    chk("rst_rise", 32'(key_rise), 32'h0);
    chk("rst_fall", 32'(key_fall), 32'h0);
    chk("rst_long", 32'(key_long), 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    step(10);
    chk("idle_out_inv", 32'(key_out), 32'h0);

    // clean press on channel 0
    key_in = 4'b0101;
    step(6);
    chk("p0_early_out", 32'(key_out), 32'h0);
    step(1);
    chk("p0_out",  32'(key_out),  32'h1);
    chk("p0_rise", 32'(key_rise), 32'h1);
    step(1);
    chk("p0_rise_end", 32'(key_rise), 32'h0);
    chk("p0_hold_out", 32'(key_out),  32'h1);

    // bounce on channel 1: 1,0,1,0 held two cycles each
    for (int p = 0; p < 4; p++) begin
      key_in[1] = (p % 2 == 0);
      repeat (2) begin
        step(1);
        chk("b1_no_rise", 32'(key_rise), 32'h0);
        chk("b1_out",     32'(key_out),  32'h1);
      end
    end
    key_in[1] = 1'b1;
    step(6);
    chk("b1_early_out", 32'(key_out), 32'h1);
    step(1);
    chk("b1_rise", 32'(key_rise), 32'h2);
    chk("b1_out2", 32'(key_out),  32'h3);

    // inverted channel 2: driving the pin low is a press
    key_in[2] = 1'b0;
    step(6);
    chk("i2_early_out", 32'(key_out), 32'h3);
    step(1);
    chk("i2_rise", 32'(key_rise), 32'h4);
    chk("i2_out",  32'(key_out),  32'h7);

    // press channel 3, then release everything at once
    key_in[3] = 1'b1;
    step(7);
    chk("p3_rise", 32'(key_rise), 32'h8);
    chk("p3_out",  32'(key_out),  32'hF);
    step(1);
    key_in = 4'b0100;
    step(6);
    chk("rel_early_out",  32'(key_out),  32'hF);
    chk("rel_early_fall", 32'(key_fall), 32'h0);
    step(1);
    chk("rel_fall", 32'(key_fall), 32'hF);
    chk("rel_rise", 32'(key_rise), 32'h0);
    chk("rel_out",  32'(key_out),  32'h0);
    step(1);
    chk("rel_fall_end", 32'(key_fall), 32'h0);

    // reset in the middle of a press window
    key_in = 4'b0110;
    step(7);
    chk("r_pre_out", 32'(key_out), 32'h2);
    key_in = 4'b0111;
    step(4);
    chk("r_mid_out", 32'(key_out), 32'h2);
    nrst = 1'b0;
    #1;
    chk("r_out",  32'(key_out),  32'h0);
    chk("r_rise", 32'(key_rise), 32'h0);
    chk("r_fall", 32'(key_fall), 32'h0);
    step(2);
    nrst = 1'b1;
    step(6);
    chk("r_early_rise", 32'(key_rise), 32'h0);
    chk("r_early_out",  32'(key_out),  32'h0);
    step(1);
    chk("r_rise2", 32'(key_rise), 32'h3);
    chk("r_out2",  32'(key_out),  32'h3);

    // long press on channel 3
    key_in = 4'b1111;
    step(7);
    chk("l3_rise", 32'(key_rise), 32'h8);
`ifdef KEY_LONGPRESS_EN
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk("l3_early", 32'(key_long), 32'h0);
    end
    step(1);
    chk("l3_long", 32'(key_long), 32'h8);
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("l3_no_repeat", 32'(key_long), 32'h0);
    end
`else
    for (int k = 0; k < 22; k++) begin
      step(1);
      chk("l3_off", 32'(key_long), 32'h0);
    end
`endif
    chk("l3_out", 32'(key_out), 32'hB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
